// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad controller: CPU register addresses,
// the open-bus read pattern, the scan-engine state encoding and small helpers.
// Latency: n/a (package). Backpressure: n/a.
package joypad_pkg;

  // CPU-visible register addresses.
  localparam logic [15:0] JOY0_ADDR = 16'h4016;
  localparam logic [15:0] JOY1_ADDR = 16'h4017;

  // Bits that are not driven by the controller on a read float to this
  // value on the CPU bus (bit 6 set).
  localparam logic [7:0] OPEN_BUS = 8'h40;

  // Scan engine states, in the order they are visited during one scan.
  typedef enum logic [2:0] {
    SCAN_IDLE  = 3'd0,
    SCAN_LATCH = 3'd1,
    SCAN_LOW   = 3'd2,
    SCAN_HIGH  = 3'd3,
    SCAN_DONE  = 3'd4
  } scan_state_t;

  // One CPU read with strobe low consumes bit 0 and feeds a 1 into bit 7,
  // so that reads past the eighth button return "pressed".
  function automatic logic [7:0] shift_in_one(input logic [7:0] v);
    return {1'b1, v[7:1]};
  endfunction

  // Byte returned to the CPU for a given button bit.
  function automatic logic [7:0] read_byte(input logic b);
    return OPEN_BUS | {7'd0, b};
  endfunction

endpackage

// File: rtl/joypad_scan.sv
// Free-running serial scan of two pads: latch pulse, seven clock pulses,
// eight samples per pad, then an atomic snapshot update.
// Latency: one scan every 32*CLK_DIV+1 cycles. Backpressure: none (free-running).
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   pad_data[1:0]     - serial data from pad 0 / pad 1, active-low
//   pad_latch         - parallel-load pulse to both pads
//   pad_clk           - shift clock to both pads, idles high
//   snapshot0/1       - last complete scan, 1 = pressed, bit i = i-th sample
//   scan0/1           - working register; equals the new snapshot while done=1
//   done              - high for the single DONE cycle of each scan
module joypad_scan
  import joypad_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] snapshot0,
  output logic [7:0] snapshot1,
  output logic [7:0] scan0,
  output logic [7:0] scan1,
  output logic       done
);

  // Phase lengths. 16*255 fits in 12 bits, the largest legal IDLE phase.
  localparam logic [11:0] IDLE_LEN  = 12'(16 * CLK_DIV);
  localparam logic [11:0] LATCH_LEN = 12'(2 * CLK_DIV);
  localparam logic [11:0] HALF_LEN  = 12'(CLK_DIV);

  scan_state_t state;
  scan_state_t state_nxt;
  logic [11:0] cnt;
  logic [11:0] cur_len;
  logic [2:0]  bit_idx;
  logic        last;
  logic        sample;

  // Length of the phase currently running.
  always_comb begin
    cur_len = 12'd1;
    case (state)
      SCAN_IDLE:           cur_len = IDLE_LEN;
      SCAN_LATCH:          cur_len = LATCH_LEN;
      SCAN_LOW, SCAN_HIGH: cur_len = HALF_LEN;
      default:             cur_len = 12'd1;
    endcase
  end

  assign last = (cnt == cur_len - 12'd1);

  always_comb begin
    state_nxt = state;
    if (last) begin
      case (state)
        SCAN_IDLE:  state_nxt = SCAN_LATCH;
        SCAN_LATCH: state_nxt = SCAN_LOW;
        SCAN_LOW:   state_nxt = SCAN_HIGH;
        SCAN_HIGH:  state_nxt = (bit_idx == 3'd7) ? SCAN_DONE : SCAN_LOW;
        // DONE, and any unreachable encoding, recovers to IDLE.
        default:    state_nxt = SCAN_IDLE;
      endcase
    end
  end

  // Bit 0 is taken at the end of the latch pulse; bits 1..7 at the end of
  // each high half, i.e. after the pad has had a full half-period to shift.
  assign sample = last && ((state == SCAN_LATCH) || (state == SCAN_HIGH));
  assign done   = (state == SCAN_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN_IDLE;
      cnt       <= 12'd0;
      bit_idx   <= 3'd0;
      scan0     <= 8'h00;
      scan1     <= 8'h00;
      snapshot0 <= 8'h00;
      snapshot1 <= 8'h00;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= last ? 12'd0 : cnt + 12'd1;

      // Pad outputs are registered from the next state so they line up
      // exactly with the state they belong to and never glitch.
      pad_latch <= (state_nxt == SCAN_LATCH);
      pad_clk   <= (state_nxt != SCAN_LOW);

      if (sample) begin
        scan0[bit_idx] <= ~pad_data[0];
        scan1[bit_idx] <= ~pad_data[1];
        bit_idx        <= bit_idx + 3'd1;
      end

      // Snapshots only ever see a complete scan.
      if (state == SCAN_DONE) begin
        snapshot0 <= scan0;
        snapshot1 <= scan1;
        bit_idx   <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/joypad_ctrl.sv
// CPU-facing joypad registers at $4016/$4017 backed by a free-running pad scan.
// Latency: read data 1 cycle after re. Backpressure: none; strobes are single-cycle.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   addr, d_in, we, re  - CPU bus: address, write data, write/read strobes
//   d_out, d_out_en     - registered read data and its one-cycle valid
//   pad_data[1:0]       - serial data from pads 0/1, active-low
//   pad_latch, pad_clk  - pad control outputs (pad_clk idles high)
module joypad_ctrl
  import joypad_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_in,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  d_out,
  output logic        d_out_en,
  input  logic [1:0]  pad_data,
  output logic        pad_latch,
  output logic        pad_clk
);

  logic       strobe;
  logic [7:0] shift0;
  logic [7:0] shift1;
  logic [7:0] snap0;
  logic [7:0] snap1;
  logic [7:0] scan0;
  logic [7:0] scan1;
  logic [7:0] load0;
  logic [7:0] load1;
  logic       scan_done;
  logic       wr_strobe;
  logic       rd0;
  logic       rd1;
  logic       rd_bit;
  logic       unused_d_in;

  // Only bit 0 of the strobe register exists.
  assign unused_d_in = ^d_in[7:1];

  joypad_scan #(
    .CLK_DIV(CLK_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .snapshot0(snap0),
    .snapshot1(snap1),
    .scan0    (scan0),
    .scan1    (scan1),
    .done     (scan_done)
  );

  // A write in the same cycle as a read wins; the read is dropped entirely.
  assign wr_strobe = we && (addr == JOY0_ADDR);
  assign rd0       = re && !we && (addr == JOY0_ADDR);
  assign rd1       = re && !we && (addr == JOY1_ADDR);

  // During DONE the snapshot register still holds the previous scan, so any
  // load in that cycle takes the freshly completed scan directly.
  assign load0 = scan_done ? scan0 : snap0;
  assign load1 = scan_done ? scan1 : snap1;

  // With strobe high the pads are "transparent": report button A of the
  // current snapshot rather than the register contents.
  always_comb begin
    rd_bit = 1'b0;
    if (rd0) begin
      rd_bit = strobe ? load0[0] : shift0[0];
    end else if (rd1) begin
      rd_bit = strobe ? load1[0] : shift1[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe   <= 1'b0;
      shift0   <= 8'h00;
      shift1   <= 8'h00;
      d_out    <= 8'h00;
      d_out_en <= 1'b0;
    end else begin
      if (wr_strobe) begin
        strobe <= d_in[0];
      end

      // Reloading whenever strobe is currently high also covers the 1->0
      // write: that cycle still sees strobe=1 and loads the snapshot.
      if (strobe) begin
        shift0 <= load0;
        shift1 <= load1;
      end else begin
        if (rd0) begin
          shift0 <= shift_in_one(shift0);
        end
        if (rd1) begin
          shift1 <= shift_in_one(shift1);
        end
      end

      d_out_en <= rd0 || rd1;
      d_out    <= (rd0 || rd1) ? read_byte(rd_bit) : 8'h00;
    end
  end

endmodule

// File: tb/tb_joypad_ctrl.sv
// Self-checking bench for joypad_ctrl with a behavioural pad model.
// Latency: n/a. Backpressure: n/a.
module tb_joypad_ctrl;

  localparam int CLK_DIV = 2;
  localparam int PERIOD = 32 * CLK_DIV + 1;
  localparam logic [15:0] A0 = 16'h4016;
  localparam logic [15:0] A1 = 16'h4017;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [7:0]  d_out;
  logic        d_out_en;
  logic [1:0]  pad_data;
  logic        pad_latch;
  logic        pad_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Buttons held on each pad, bit i = i-th button in serial order, 1 = pressed.
  logic [7:0] buttons [2];
  logic [3:0] pad_idx = 4'd0;

  joypad_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .d_in     (d_in),
    .we       (we),
    .re       (re),
    .d_out    (d_out),
    .d_out_en (d_out_en),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; at a negedge it names the current cycle.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Pad shift-register model: latch presents button 0, each rising pad_clk
  // presents the next button; past the eighth it outputs 0 (pressed).
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_idx <= 4'd0;
    else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
  end

  always_comb begin
    pad_data = 2'b00;
    if (pad_idx < 4'd8)
      pad_data = {~buttons[1][pad_idx[2:0]], ~buttons[0][pad_idx[2:0]]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // k-th read after strobe falls: button k for k<8, "pressed" afterwards.
  function automatic logic [7:0] exp_byte(input logic [7:0] snap, input int k);
    if (k >= 8) return 8'h41;
    return snap[k[2:0]] ? 8'h41 : 8'h40;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while ((cyc % PERIOD) != ph && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 4 * PERIOD) else begin
      errors++;
      $error("FAIL wait_phase%0d: waited %0d cycles, limit %0d", ph, n, 4 * PERIOD);
    end
  endtask

  // Advance to the start of the next scan; a DONE always precedes it.
  task automatic next_scan();
    @(negedge clk);
    wait_phase(0);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; d_in = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 16'h0000; d_in = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic en);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0; addr = 16'h0000;
    d = d_out;
    en = d_out_en;
  endtask

  initial begin
    logic [7:0] rd;
    logic       en;
    logic [7:0] snap_m [2];
    int         cnt [2];
    int         lat, pulses, badlen, lowlen, n, p;

    buttons[0] = 8'h00;
    buttons[1] = 8'h00;
    do_reset();

    // Reset state.
    check("rst_latch", {7'd0, pad_latch}, 8'h00);
    check("rst_padclk", {7'd0, pad_clk}, 8'h01);
    check("rst_dout", d_out, 8'h00);
    check("rst_douten", {7'd0, d_out_en}, 8'h00);
    bus_read(A0, rd, en);
    check("rst_read", rd, 8'h40);
    check("rst_read_en", {7'd0, en}, 8'h01);
    bus_read(16'h4018, rd, en);
    check("unmapped_en", {7'd0, en}, 8'h00);

    // Pad timing over one full scan.
    n = 0;
    while (pad_latch !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("latch_seen", {7'd0, pad_latch}, 8'h01);
    lat = 0; pulses = 0; badlen = 0; lowlen = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (pad_latch) lat++;
      if (!pad_clk) lowlen++;
      else if (lowlen != 0) begin
        pulses++;
        if (lowlen != CLK_DIV) badlen++;
        lowlen = 0;
      end
      @(negedge clk);
    end
    check("latch_len", 8'(lat), 8'(2 * CLK_DIV));
    check("clk_pulses", 8'(pulses), 8'd7);
    check("clk_badlen", 8'(badlen), 8'd0);
    check("scan_period", {7'd0, pad_latch}, 8'h01);

    // Pad 0: A and Start pressed, serial readout.
    wait_phase(0);
    buttons[0] = 8'h09;
    next_scan();
    bus_write(A0, 8'h01);
    bus_write(A0, 8'h00);
    for (int k = 0; k < 9; k++) begin
      bus_read(A0, rd, en);
      check($sformatf("s1_read%0d", k), rd, exp_byte(8'h09, k));
    end
    @(negedge clk);
    check("s1_idle_en", {7'd0, d_out_en}, 8'h00);
    check("s1_idle_dout", d_out, 8'h00);

    // Strobe held high: repeated reads return A without shifting.
    wait_phase(0);
    buttons[0] = 8'h01;
    next_scan();
    bus_write(A0, 8'h01);
    for (int k = 0; k < 3; k++) begin
      bus_read(A0, rd, en);
      check($sformatf("s2_read%0d", k), rd, 8'h41);
    end
    bus_write(A0, 8'h00);
    bus_read(A0, rd, en);
    check("s2_after_a", rd, 8'h41);
    bus_read(A0, rd, en);
    check("s2_after_b", rd, 8'h40);

    // Strobe fall coinciding with DONE, pad 1 Right newly pressed.
    wait_phase(0);
    buttons[1] = 8'h80;
    bus_write(A0, 8'h01);
    wait_phase(PERIOD - 1);
    bus_write(A0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      bus_read(A1, rd, en);
      check($sformatf("s4_read%0d", k), rd, exp_byte(8'h80, k));
    end

    // Simultaneous write and read: write takes effect, read is dropped.
    addr = A0; d_in = 8'h01; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0; addr = 16'h0000; d_in = 8'h00;
    check("s6_en", {7'd0, d_out_en}, 8'h00);
    check("s6_dout", d_out, 8'h00);
    bus_read(A0, rd, en);
    check("s6_strobe_rd0", rd, 8'h41);
    bus_read(A0, rd, en);
    check("s6_strobe_rd1", rd, 8'h41);
    bus_write(A0, 8'h00);

    // Random button patterns, interleaved reads of both ports.
    for (int it = 0; it < 6; it++) begin
      wait_phase(0);
      buttons[0] = 8'($urandom());
      buttons[1] = 8'($urandom());
      snap_m[0] = buttons[0];
      snap_m[1] = buttons[1];
      next_scan();
      bus_write(A0, 8'h01);
      bus_write(A0, 8'h00);
      cnt[0] = 0;
      cnt[1] = 0;
      for (int r = 0; r < 14; r++) begin
        p = int'($urandom_range(0, 1));
        bus_read((p == 1) ? A1 : A0, rd, en);
        check($sformatf("rand%0d_p%0d_k%0d", it, p, cnt[p]), rd, exp_byte(snap_m[p], cnt[p]));
        cnt[p]++;
      end
    end

    // Reset in the middle of a scan.
    buttons[0] = 8'hFF;
    wait_phase(33);
    check("s5_pre_latch", {7'd0, pad_latch}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5_latch_rel", {7'd0, pad_latch}, 8'h00);
    check("s5_padclk_a", {7'd0, pad_clk}, 8'h01);
    wait_phase(40);
    check("s5_pre_clk", {7'd0, pad_clk}, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5_padclk_b", {7'd0, pad_clk}, 8'h01);
    check("s5_latch_b", {7'd0, pad_latch}, 8'h00);
    bus_read(A0, rd, en);
    check("s5_read", rd, 8'h40);
    bus_write(A0, 8'h01);
    bus_read(A0, rd, en);
    check("s5_snap_clear", rd, 8'h40);
    next_scan();
    bus_read(A0, rd, en);
    check("s5_rescan", rd, 8'h41);
    bus_write(A0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joypad_ctrl.md
JOYPAD_CTRL -- requirements
Module: joypad_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 6: pad serial half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL have port addr, input, 16, CPU bus address.
REQ-005 SHALL have port d_in, input, 8, CPU write data.
REQ-006 SHALL have port we, input, 1, CPU write strobe for one cycle.
REQ-007 SHALL have port re, input, 1, CPU read strobe for one cycle.
REQ-008 SHALL have port d_out, output, 8, read data to CPU.
REQ-009 SHALL have port d_out_en, output, 1, d_out valid for one cycle.
REQ-010 SHALL have port pad_data, input, 2, serial data from pads 0 and 1; it is active-low (0 = pressed).
REQ-011 SHALL have port pad_latch, output, 1, parallel-load pulse to both pads.
REQ-012 SHALL have port pad_clk, output, 1, shift clock to both pads; it idles high.

Function
REQ-013 The CPU-side decode SHALL be: we at $4016 sets strobe = d_in[0]; re at $4016 reads port 0; re at $4017 reads port 1; all other addresses get no response.
REQ-014 When we and re are both high in the same cycle, the block SHALL perform the write and ignore the read.
REQ-015 A read SHALL be registered: d_out and d_out_en are valid exactly 1 cycle after re, d_out_en is high for 1 cycle, and otherwise d_out = 0.
REQ-016 Read data SHALL be d_out = {8'h40 | bit}, where bit = shift[0] of the addressed port (bit 6 models open bus).
REQ-017 A read with strobe = 0 SHALL shift that port's register right by one with 1 entering bit 7, so a ninth and later read return bit = 1.
REQ-018 While strobe = 1, both shift registers SHALL reload from the snapshots every cycle, and reads SHALL return snapshot bit 0 (button A) without shifting.
REQ-019 A write that takes strobe 1->0 SHALL load both shift registers from the snapshots.
REQ-020 The scan engine SHALL run continuously and independently of the CPU side, using states IDLE, LATCH, LOW, HIGH and DONE.
REQ-021 IDLE SHALL last 16*CLK_DIV cycles and then go to LATCH.
REQ-022 LATCH SHALL drive pad_latch = 1 for 2*CLK_DIV cycles and sample bit 0 (A) on its last cycle, then go to LOW.
REQ-023 LOW SHALL drive pad_clk = 0 for CLK_DIV cycles and then go to HIGH.
REQ-024 HIGH SHALL drive pad_clk = 1 for CLK_DIV cycles and sample the next bit on its last cycle.
REQ-025 After HIGH, the engine SHALL return to LOW until bits 1..7 are sampled (order A, B, Select, Start, Up, Down, Left, Right), then go to DONE.
REQ-026 DONE SHALL last 1 cycle, update both snapshots, then go to IDLE, giving a scan period of 32*CLK_DIV+1 cycles.
REQ-027 Snapshots SHALL store inverted pad_data, so 1 = pressed, with bit i = i-th sampled bit.
REQ-028 When DONE coincides with a strobe 1->0 write or strobe = 1, the shift registers SHALL load the new snapshot values (bypass).
REQ-029 Scan samples SHALL be taken into a working register, so snapshots never hold a partial scan.

Reset
REQ-030 On rst, the block SHALL set strobe = 0, both snapshots = 8'h00, both shift registers = 8'h00, d_out = 0, d_out_en = 0, pad_latch = 0, pad_clk = 1, and the engine to IDLE with its counter cleared.
REQ-031 A reset asserted mid-scan SHALL abort the scan, leave the snapshots at 0 and release pad_latch the next cycle.

Structure
REQ-032 A shared package SHALL hold the constants JOY0_ADDR = 16'h4016 and JOY1_ADDR = 16'h4017, the open-bus constant 8'h40, and the scan-state enum.
REQ-033 The scan engine (REQ-020..029) SHALL be one sub-module, joypad_scan, which outputs snapshot0, snapshot1 and a done pulse; joypad_ctrl holds the decode and the shift registers.

Verification
REQ-034 The bench SHALL cover scenario 1: CLK_DIV = 2 with pad0 serial pattern A and Start pressed -> after a DONE, write 1 then 0 to $4016 and read $4016 eight times -> bits 1,0,0,1,0,0,0,0, d_out = 8'h41 / 8'h40, then a 9th read returns 8'h41.
REQ-035 The bench SHALL cover scenario 2: strobe held at 1 with A pressed and read $4016 three times -> 8'h41 each time, with no shifting.
REQ-036 The bench SHALL cover scenario 3: check pad timing with CLK_DIV = 2 -> pad_latch high 4 cycles, then 7 pad_clk low pulses of 2 cycles each, and a scan period of 65 cycles.
REQ-037 The bench SHALL cover scenario 4: a strobe 1->0 write in the same cycle as DONE with pad1 Right newly pressed -> reads of $4017 return seven 8'h40 and then 8'h41.
REQ-038 The bench SHALL cover scenario 5: rst asserted during SHIFT -> next cycle pad_latch = 0 and pad_clk = 1, and a $4016 read returns 8'h40.
REQ-039 The bench SHALL cover scenario 6: we and re together at $4016 with d_in = 1 -> strobe = 1 and d_out_en stays 0.
